// File: rtl/cache_miss_ctrl_if.sv
// Bundle between the cache miss controller and its requester, cache and main memory.
// master = system side (CPU, cache arrays, memory); slave = the controller.
interface cache_miss_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int INDEX_W = 3,
    parameter int DATA_W  = 8
);
    localparam int TAG_W = ADDR_W - INDEX_W;

    logic              req_valid;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;

    logic [ADDR_W-1:0] cache_addr;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_rdata;
    logic              victim_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic [DATA_W-1:0] victim_data;
    logic              fill_valid;
    logic [DATA_W-1:0] fill_data;
    logic              fill_dirty;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_wren, req_addr, req_data,
        input  req_ready,
        input  cache_addr,
        output cache_hit, cache_rdata, victim_dirty, victim_tag, victim_data,
        input  fill_valid, fill_data, fill_dirty,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_wren, req_addr, req_data,
        output req_ready,
        output cache_addr,
        input  cache_hit, cache_rdata, victim_dirty, victim_tag, victim_data,
        output fill_valid, fill_data, fill_dirty,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Request sequencer in front of the 2-way cache: lookup, dirty write-back, line fetch, refill, response.
// Define CACHE_MISS_CTRL_STATS_EN to add saturating hit/miss/write-back counters.
module cache_miss_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int INDEX_W     = 3,
    parameter int DATA_W      = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
`ifdef CACHE_MISS_CTRL_STATS_EN
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count,
    output logic [7:0]        wb_count,
`endif
    cache_miss_ctrl_if.slave  bus
);
    localparam logic [3:0] TIMEOUT_LIM = 4'(MEM_TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, FETCH, FILL, RESP} state_t;

    state_t            state;
    logic              req_ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wren_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wait_cnt;
    logic              fill_valid_q;
    logic [DATA_W-1:0] fill_data_q;
    logic              fill_dirty_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              resp_err_q;

    logic wait_last;
    logic store_hit;

    assign wait_last = (wait_cnt + 4'd1) == TIMEOUT_LIM;
    // A store hit must write the cache during LOOKUP itself, so that strobe bypasses the registers.
    assign store_hit = (state == LOOKUP) && wren_q && bus.cache_hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_ready_q  <= 1'b1;
            addr_q       <= '0;
            wren_q       <= 1'b0;
            wdata_q      <= '0;
            wait_cnt     <= '0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= '0;
            fill_dirty_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            fill_valid_q <= 1'b0;
            fill_dirty_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        wren_q      <= bus.req_wren;
                        wdata_q     <= bus.req_data;
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    wait_cnt <= '0;
                    if (bus.cache_hit) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= wren_q ? '0 : bus.cache_rdata;
                        state        <= RESP;
                    end else if (bus.victim_dirty) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {bus.victim_tag, addr_q[INDEX_W-1:0]};
                        mem_wdata_q <= bus.victim_data;
                        state       <= WBACK;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_q;
                        state      <= FETCH;
                    end
                end
                WBACK, FETCH: begin
                    // An ack arriving on the last allowed cycle still completes the transfer.
                    if (bus.mem_ack) begin
                        wait_cnt    <= '0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        if (state == WBACK) begin
                            mem_addr_q <= addr_q;
                            state      <= FETCH;
                        end else begin
                            mem_req_q    <= 1'b0;
                            mem_addr_q   <= '0;
                            fill_valid_q <= 1'b1;
                            fill_data_q  <= wren_q ? wdata_q : bus.mem_rdata;
                            fill_dirty_q <= wren_q;
                            state        <= FILL;
                        end
                    end else if (wait_last) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_data_q  <= '0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                FILL: begin
                    resp_valid_q <= 1'b1;
                    resp_data_q  <= wren_q ? '0 : fill_data_q;
                    state        <= RESP;
                end
                RESP: begin
                    resp_data_q <= '0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.cache_addr = addr_q;
    assign bus.fill_valid = fill_valid_q | store_hit;
    assign bus.fill_data  = store_hit ? wdata_q : fill_data_q;
    assign bus.fill_dirty = fill_dirty_q | store_hit;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

`ifdef CACHE_MISS_CTRL_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Write-back entry coincides with a dirty-victim miss in LOOKUP.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (state == LOOKUP) begin
            if (bus.cache_hit) begin
                hit_count <= sat_inc(hit_count);
            end else begin
                miss_count <= sat_inc(miss_count);
                if (bus.victim_dirty) wb_count <= sat_inc(wb_count);
            end
        end
    end
`else
    // Statistics counters are not built.
`endif
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: expected memory transactions, fills and responses are
// queued as each request is issued and retired by monitors as the controller produces them.
module tb_cache_miss_ctrl;
    localparam int ADDR_W  = 5;
    localparam int INDEX_W = 3;
    localparam int DATA_W  = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cache_miss_ctrl_if #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W)) bus ();

`ifdef CACHE_MISS_CTRL_STATS_EN
    logic [7:0] hit_count, miss_count, wb_count;
`endif

    cache_miss_ctrl #(
        .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .DATA_W(DATA_W), .MEM_TIMEOUT(15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
`ifdef CACHE_MISS_CTRL_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count),
`endif
        .bus        (bus)
    );

    typedef struct {logic [7:0] data; logic err; int lat;} resp_t;
    typedef struct {logic [7:0] data; logic dirty; int lat;} fill_t;
    typedef struct {logic we; logic [4:0] addr; logic [7:0] wdata; int delay; logic [7:0] rdata;} mem_t;

    resp_t resp_q[$];
    fill_t fill_q[$];
    mem_t  mem_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int txn_len = 0;
    int exp_hit = 0, exp_miss = 0, exp_wb = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic exp_resp(input logic [7:0] d, input logic e, input int lat);
        resp_t r;
        r.data = d; r.err = e; r.lat = lat;
        resp_q.push_back(r);
    endtask

    task automatic exp_fill(input logic [7:0] d, input logic dirty, input int lat);
        fill_t f;
        f.data = d; f.dirty = dirty; f.lat = lat;
        fill_q.push_back(f);
    endtask

    task automatic exp_mem(input logic we, input logic [4:0] a, input logic [7:0] wd,
                           input int delay, input logic [7:0] rd);
        mem_t m;
        m.we = we; m.addr = a; m.wdata = wd; m.delay = delay; m.rdata = rd;
        mem_q.push_back(m);
    endtask

    task automatic set_cache(input logic hit, input logic [7:0] rdata, input logic vdirty,
                             input logic [1:0] vtag, input logic [7:0] vdata);
        bus.cache_hit    = hit;
        bus.cache_rdata  = rdata;
        bus.victim_dirty = vdirty;
        bus.victim_tag   = vtag;
        bus.victim_data  = vdata;
    endtask

    task automatic issue(input logic wr, input logic [4:0] a, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_wait", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wren  = wr;
        bus.req_addr  = a;
        bus.req_data  = d;
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wren  = 1'b0;
        bus.req_data  = '0;
        chk("cache_addr", bus.cache_addr, a);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() + fill_q.size() + mem_q.size()) != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        chk("drain_pending", resp_q.size() + fill_q.size() + mem_q.size(), 0);
        resp_q.delete();
        fill_q.delete();
        mem_q.delete();
        repeat (2) @(posedge clock);
    endtask

    // Memory model: checks each transaction as it opens, holds it stable, acks after its delay.
    initial begin
        mem_t cur;
        bit   in_txn;
        int   cnt;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        in_txn = 0;
        cnt = 0;
        cur.we = 0; cur.addr = '0; cur.wdata = '0; cur.delay = -1; cur.rdata = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_ack) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
                in_txn = 0;
            end
            if (bus.mem_req) begin
                if (!in_txn) begin
                    in_txn = 1;
                    cnt = 0;
                    if (mem_q.size() == 0) begin
                        chk("mem_unexpected", 1, 0);
                        cur.we = bus.mem_we; cur.addr = bus.mem_addr; cur.wdata = bus.mem_wdata;
                        cur.delay = -1; cur.rdata = '0;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                    chk("mem_we", bus.mem_we, cur.we);
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    chk("mem_wdata", bus.mem_wdata, cur.wdata);
                end else begin
                    chk("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                        {cur.we, cur.addr, cur.wdata});
                end
                if (cur.delay == cnt) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = cur.rdata;
                end
                cnt++;
                txn_len = cnt;
            end else begin
                in_txn = 0;
                chk("mem_idle", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
            end
        end
    end

    initial begin
        resp_t r;
        forever begin
            @(negedge clock);
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_data", bus.resp_data, r.data);
                    chk("resp_err", bus.resp_err, r.err);
                    chk("resp_latency", cyc - acc_cyc, r.lat);
                end
            end
        end
    end

    initial begin
        fill_t f;
        forever begin
            @(negedge clock);
            if (bus.fill_valid) begin
                if (fill_q.size() == 0) begin
                    chk("fill_unexpected", 1, 0);
                end else begin
                    f = fill_q.pop_front();
                    chk("fill_data", bus.fill_data, f.data);
                    chk("fill_dirty", bus.fill_dirty, f.dirty);
                    chk("fill_latency", cyc - acc_cyc, f.lat);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req_valid = 1'b0;
        bus.req_wren  = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        set_cache(1'b0, 8'h00, 1'b0, 2'b00, 8'h00);

        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_fill_resp", {bus.fill_valid, bus.fill_data, bus.fill_dirty,
                              bus.resp_valid, bus.resp_data, bus.resp_err}, 0);
        chk("rst_mem_addr", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                             bus.cache_addr}, 0);
        reset = 1'b0;

        // Load hit
        set_cache(1'b1, 8'h3C, 1'b0, 2'b00, 8'h00);
        exp_resp(8'h3C, 1'b0, 2);
        issue(1'b0, 5'h0A, 8'h00);
        drain();
        exp_hit = sat(exp_hit);

        // Store hit: fill during LOOKUP, response carries zero
        set_cache(1'b1, 8'hEE, 1'b0, 2'b00, 8'h00);
        exp_fill(8'h77, 1'b1, 1);
        exp_resp(8'h00, 1'b0, 2);
        issue(1'b1, 5'h11, 8'h77);
        drain();
        exp_hit = sat(exp_hit);

        // Clean load miss, memory answers after 3 wait cycles
        set_cache(1'b0, 8'hEE, 1'b0, 2'b01, 8'h12);
        exp_mem(1'b0, 5'h13, 8'h00, 3, 8'hA5);
        exp_fill(8'hA5, 1'b0, 6);
        exp_resp(8'hA5, 1'b0, 7);
        issue(1'b0, 5'h13, 8'h00);
        drain();
        exp_miss = sat(exp_miss);

        // Dirty load miss: write-back of {11,010}, then fetch
        set_cache(1'b0, 8'h00, 1'b1, 2'b11, 8'h5E);
        exp_mem(1'b1, 5'h1A, 8'h5E, 2, 8'h00);
        exp_mem(1'b0, 5'h02, 8'h00, 1, 8'hC3);
        exp_fill(8'hC3, 1'b0, 7);
        exp_resp(8'hC3, 1'b0, 8);
        issue(1'b0, 5'h02, 8'h00);
        drain();
        exp_miss = sat(exp_miss);
        exp_wb = sat(exp_wb);

        // Store miss, write-allocate with immediate ack
        set_cache(1'b0, 8'h00, 1'b0, 2'b00, 8'h00);
        exp_mem(1'b0, 5'h07, 8'h00, 0, 8'h11);
        exp_fill(8'h99, 1'b1, 3);
        exp_resp(8'h00, 1'b0, 4);
        issue(1'b1, 5'h07, 8'h99);
        drain();
        exp_miss = sat(exp_miss);

        // Memory never acks: 15 request cycles, error response, no fill
        exp_mem(1'b0, 5'h15, 8'h00, -1, 8'h00);
        exp_resp(8'h00, 1'b1, 17);
        issue(1'b0, 5'h15, 8'h00);
        drain();
        chk("timeout_req_cycles", txn_len, 15);
        exp_miss = sat(exp_miss);

        // Ack on the same cycle the wait limit is reached: ack wins
        exp_mem(1'b0, 5'h05, 8'h00, 14, 8'h4D);
        exp_fill(8'h4D, 1'b0, 17);
        exp_resp(8'h4D, 1'b0, 18);
        issue(1'b0, 5'h05, 8'h00);
        drain();
        exp_miss = sat(exp_miss);

`ifdef CACHE_MISS_CTRL_STATS_EN
        chk("hit_count_a", hit_count, exp_hit);
        chk("miss_count_a", miss_count, exp_miss);
        chk("wb_count_a", wb_count, exp_wb);
`endif

        // Reset while waiting in FETCH
        exp_mem(1'b0, 5'h09, 8'h00, -1, 8'h00);
        issue(1'b0, 5'h09, 8'h00);
        n = 0;
        while (!bus.mem_req && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("fetch_started", bus.mem_req, 1);
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mem_req", bus.mem_req, 0);
        chk("rst_async_req_ready", bus.req_ready, 1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        mem_q.delete();
        repeat (3) @(negedge clock);
        chk("post_rst_req_ready", bus.req_ready, 1);
`ifdef CACHE_MISS_CTRL_STATS_EN
        chk("miss_count_rst", miss_count, 0);
`endif

        // 300 load hits drive the hit counter into saturation
        for (int i = 0; i < 300; i++) begin
            set_cache(1'b1, 8'(i * 7), 1'b0, 2'b00, 8'h00);
            exp_resp(8'(i * 7), 1'b0, 2);
            issue(1'b0, 5'(i), 8'h00);
            drain();
            exp_hit = sat(exp_hit);
        end

        // One more dirty miss after the reset, both transfers acked at once
        set_cache(1'b0, 8'h00, 1'b1, 2'b10, 8'h66);
        exp_mem(1'b1, 5'h14, 8'h66, 0, 8'h00);
        exp_mem(1'b0, 5'h04, 8'h00, 0, 8'h21);
        exp_fill(8'h21, 1'b0, 4);
        exp_resp(8'h21, 1'b0, 5);
        issue(1'b0, 5'h04, 8'h00);
        drain();
        exp_miss = sat(exp_miss);
        exp_wb = sat(exp_wb);

`ifdef CACHE_MISS_CTRL_STATS_EN
        chk("hit_count_sat", hit_count, exp_hit);
        chk("miss_count_b", miss_count, exp_miss);
        chk("wb_count_b", wb_count, exp_wb);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
